imem_dmem_arbiter: RTL and testbench
====================================

# imem_dmem_arbiter

Shares one single-ported unified memory between the hart's instruction-fetch port and its load/store port. Real memory has one port, unlike the split instruction and data banks used in simulation. Grants one request per cycle, with data priority bounded by an anti-starvation counter. Tracks in-flight reads through a fixed-latency tag pipeline so each read response returns to the requester that issued it.

## Interface
- `LATENCY`, 1 — cycles from grant to `i_mem_rdata` valid; legal range 1..4.
- `MAX_DSTREAK`, 4 — maximum consecutive data grants while a fetch waits; legal range 1..15.
- `i_clk`  in  1  — clock; all state changes on the rising edge.
- `i_rst_n`  in  1  — reset, asynchronous and active-low.
- `i_if_req`  in  1  — fetch request; held, with a stable address, until granted.
- `i_if_addr`  in  32  — fetch byte address, word-aligned.
- `o_if_gnt`  out  1  — fetch accepted this cycle.
- `o_if_rvalid`  out  1  — fetch read data valid.
- `o_if_rdata`  out  32  — fetch read data; 0 when `o_if_rvalid` is low.
- `i_d_req`  in  1  — data request; held, with stable payload, until granted.
- `i_d_wen`  in  1  — 1 = store, 0 = load.
- `i_d_addr`  in  32  — data byte address.
- `i_d_wdata`  in  32  — store data.
- `i_d_mask`  in  4  — byte enables.
- `o_d_gnt`  out  1  — data request accepted this cycle.
- `o_d_rvalid`  out  1  — load data valid.
- `o_d_rdata`  out  32  — load data; 0 when `o_d_rvalid` is low.
- `o_mem_req`  out  1  — memory access this cycle.
- `o_mem_wen`  out  1  — memory write enable.
- `o_mem_addr`  out  32  — memory address.
- `o_mem_wdata`  out  32  — memory write data.
- `o_mem_mask`  out  4  — memory byte enables.
- `i_mem_rdata`  in  32  — memory read data, valid `LATENCY` cycles after the read issues.

## Operation
- **Memory side.** The memory accepts one access every cycle and never stalls.
- **Grant logic (combinational).**
  - Only `i_d_req` asserted: grant data.
  - Only `i_if_req` asserted: grant fetch.
  - Both asserted: grant data, unless `dstreak == MAX_DSTREAK`; then grant fetch.
- **Streak counter `dstreak`.**
  - Width 4, reset value 0.
  - Increments, saturating at `MAX_DSTREAK`, on a data grant while `i_if_req` is high.
  - Clears on any fetch grant, or in any cycle where `i_if_req` is low.
- **Memory mux.**
  - `o_mem_*` drives the granted source's fields.
  - Fetch grants drive `wen=0` and `mask=4'b1111`.
  - With no grant, all `o_mem_*` outputs are 0.
- **Tag pipeline.**
  - `LATENCY` stages, each holding {valid, src}; src: 0 = fetch, 1 = data.
  - Stage 0 loads valid=1 on a fetch grant or a data load grant. Stores load valid=0; stores produce no response.
  - Each stage shifts by one every cycle.
- **Response routing.**
  - The final stage, when valid, routes `i_mem_rdata` to `o_if_rdata`/`o_if_rvalid` or `o_d_rdata`/`o_d_rvalid` according to src.
  - The other source's rvalid and rdata stay 0.
- **Ordering.** Responses come back in grant order, one per cycle at most. Back-to-back grants give back-to-back responses.
- **Requester obligations.** A requester deasserts `req` for the cycle after its grant, or presents a new request. Changing the payload while `req` is high and ungranted is illegal and is not checked.
- **Reset.**
  - Asserting `i_rst_n` low at any time immediately clears every tag stage and `dstreak`.
  - In-flight responses are dropped. No rvalid appears after reset, even if the memory still returns data.

## Timing
- `gnt` and `o_mem_*` are combinational from the current requests and `dstreak`, so a request is granted in the cycle it is presented if it wins.
- Read response: rvalid is high exactly `LATENCY` cycles after the grant cycle. rvalid is registered (tag stage); rdata is the `i_mem_rdata` pass-through, gated by rvalid.
- Outputs during reset:
  - `o_if_gnt`, `o_d_gnt`, `o_mem_req`, `o_if_rvalid`, `o_d_rvalid` = 0.
  - All data and address outputs = 0.
  - Grants are forced to 0 while `i_rst_n` is low.
- Simultaneous events:
  - A data grant while the final stage returns a fetch response is legal; both happen in the same cycle.
  - The streak counter updates in the same cycle it is evaluated; the new value takes effect the next cycle.
- With `MAX_DSTREAK = N` and continuous requests from both sides, the steady-state pattern is N data grants, then 1 fetch grant, repeating.

## Test plan
- **Lone fetch.** `LATENCY=1`, fetch to 0x0000_0010 with memory returning 0x0051_3023 → `o_if_gnt` high in the request cycle; next cycle `o_if_rvalid=1`, `o_if_rdata=0x0051_3023`, `o_d_rvalid=0`.
- **Both request every cycle.** `MAX_DSTREAK=4` → grant sequence D,D,D,D,I,D,D,D,D,I. Responses return in that order, each tagged to the correct port.
- **Store vs load.** Store to 0x100 with `mask=4'b0011` and `wdata=0xDEAD_BEEF` → `o_mem_wen=1`, `o_mem_mask=4'b0011`, no rvalid. A load of 0x100 in the next cycle → `o_d_rvalid` exactly `LATENCY` cycles later.
- **Back-to-back with LATENCY=3.** Grants in cycles 0, 1, 2 → responses in cycles 3, 4, 5, in order.
- **Reset mid-flight.** `LATENCY=3`, two loads outstanding, `i_rst_n` pulsed low between clock edges → all rvalid and gnt outputs go 0 immediately. No response appears after release, and `dstreak` restarts at 0.
- **Streak clear.** Three data grants while a fetch waits, then `i_if_req` drops for one cycle, then both request → data is granted for 4 more cycles before the fetch wins.

Source files
------------

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the hart's fetch/load-store ports, the arbiter and the
// unified single-ported memory. Signal names match the arbiter's port names.
interface imem_dmem_arbiter_if;
  // fetch port
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  // load/store port
  logic        i_d_req;
  logic        i_d_wen;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_mask;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  // memory port
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic [31:0] i_mem_rdata;

  // arbiter side
  modport slave (
    input  i_if_req, i_if_addr,
    input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    input  i_mem_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
  );

  // requester + memory side
  modport master (
    output i_if_req, i_if_addr,
    output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    output i_mem_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. Data wins ties, bounded by a streak counter so a waiting fetch
// gets through after MAX_DSTREAK data grants. A fixed-latency tag pipeline
// steers each read response back to the port that issued it.
module imem_dmem_arbiter #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  imem_dmem_arbiter_if.slave    bus
);

  localparam logic [3:0] MAX_D = 4'(MAX_DSTREAK);

  logic [3:0]         dstreak_q, dstreak_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_src_q, tag_src_d;
  logic               if_gnt, d_gnt;

  // Grant: data first unless the streak limit is hit while a fetch waits;
  // both grants are held off while reset is asserted.
  always_comb begin
    d_gnt  = i_rst_n & bus.i_d_req & ~(bus.i_if_req & (dstreak_q == MAX_D));
    if_gnt = i_rst_n & bus.i_if_req & ~d_gnt;
  end

  // Memory mux: drive the winner's fields, all zero when idle.
  always_comb begin
    bus.o_if_gnt    = if_gnt;
    bus.o_d_gnt     = d_gnt;
    bus.o_mem_req   = if_gnt | d_gnt;
    bus.o_mem_wen   = d_gnt & bus.i_d_wen;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_mask  = '0;
    if (d_gnt) begin
      bus.o_mem_addr  = bus.i_d_addr;
      bus.o_mem_wdata = bus.i_d_wdata;
      bus.o_mem_mask  = bus.i_d_mask;
    end else if (if_gnt) begin
      bus.o_mem_addr  = bus.i_if_addr;
      bus.o_mem_mask  = '1;
    end
  end

  // Next state: streak counter and tag shift register.
  always_comb begin
    dstreak_d = dstreak_q;
    if (if_gnt || !bus.i_if_req) begin
      dstreak_d = '0;
    end else if (d_gnt && (dstreak_q != MAX_D)) begin
      dstreak_d = dstreak_q + 4'd1;
    end

    tag_vld_d = '0;
    tag_src_d = '0;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_src_d[i] = tag_src_q[i-1];
    end
    tag_vld_d[0] = if_gnt | (d_gnt & ~bus.i_d_wen);
    tag_src_d[0] = d_gnt;
  end

  // State registers; reset drops every in-flight response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dstreak_q <= '0;
      tag_vld_q <= '0;
      tag_src_q <= '0;
    end else begin
      dstreak_q <= dstreak_d;
      tag_vld_q <= tag_vld_d;
      tag_src_q <= tag_src_d;
    end
  end

  // Response routing from the final tag stage; rdata gated by rvalid.
  always_comb begin
    bus.o_if_rvalid = tag_vld_q[LATENCY-1] & ~tag_src_q[LATENCY-1];
    bus.o_d_rvalid  = tag_vld_q[LATENCY-1] &  tag_src_q[LATENCY-1];
    bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_mem_rdata : '0;
    bus.o_d_rdata   = bus.o_d_rvalid  ? bus.i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: two instances (LATENCY 1 and 3)
// receive identical requests; each has its own memory model and response
// scoreboard.
module tb_imem_dmem_arbiter;

  localparam int NONE = 0;
  localparam int FI   = 1;
  localparam int DA   = 2;

  typedef struct {
    logic        src;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  resp_t q1[$];
  resp_t q3[$];

  logic [31:0] refmem [256];
  logic [31:0] mem1   [256];
  logic [31:0] mem3   [256];
  logic [31:0] pipe1;
  logic [31:0] pipe3  [3];

  imem_dmem_arbiter_if b1 ();
  imem_dmem_arbiter_if b3 ();

  imem_dmem_arbiter #(.LATENCY(1), .MAX_DSTREAK(4)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (b1.slave)
  );

  imem_dmem_arbiter #(.LATENCY(3), .MAX_DSTREAK(4)) u_dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: one access per cycle, read data after the instance latency.
  always @(posedge clk) begin
    pipe1 <= (b1.o_mem_req && !b1.o_mem_wen) ? mem1[b1.o_mem_addr[9:2]] : (32'hBAD0_0000 ^ cyc);
    if (b1.o_mem_req && b1.o_mem_wen)
      for (int b = 0; b < 4; b++)
        if (b1.o_mem_mask[b]) mem1[b1.o_mem_addr[9:2]][8*b +: 8] <= b1.o_mem_wdata[8*b +: 8];
    pipe3[0] <= (b3.o_mem_req && !b3.o_mem_wen) ? mem3[b3.o_mem_addr[9:2]] : (32'hBAD3_0000 ^ cyc);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (b3.o_mem_req && b3.o_mem_wen)
      for (int b = 0; b < 4; b++)
        if (b3.o_mem_mask[b]) mem3[b3.o_mem_addr[9:2]][8*b +: 8] <= b3.o_mem_wdata[8*b +: 8];
  end
  assign b1.i_mem_rdata = pipe1;
  assign b3.i_mem_rdata = pipe3[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboards, compared on the falling edge.
  always @(negedge clk) begin
    logic  due;
    resp_t e;
    due = (q1.size() > 0) && (q1[0].cyc == cyc);
    chk("L1 rvalid {if,d}", {62'd0, b1.o_if_rvalid, b1.o_d_rvalid},
        due ? (q1[0].src ? 64'd1 : 64'd2) : 64'd0);
    if (due) begin
      e = q1.pop_front();
      chk("L1 rdata", e.src ? b1.o_d_rdata : b1.o_if_rdata, {32'd0, e.data});
      chk("L1 other rdata", e.src ? b1.o_if_rdata : b1.o_d_rdata, 64'd0);
    end else begin
      chk("L1 idle rdata", {b1.o_if_rdata, b1.o_d_rdata}, 64'd0);
    end

    due = (q3.size() > 0) && (q3[0].cyc == cyc);
    chk("L3 rvalid {if,d}", {62'd0, b3.o_if_rvalid, b3.o_d_rvalid},
        due ? (q3[0].src ? 64'd1 : 64'd2) : 64'd0);
    if (due) begin
      e = q3.pop_front();
      chk("L3 rdata", e.src ? b3.o_d_rdata : b3.o_if_rdata, {32'd0, e.data});
      chk("L3 other rdata", e.src ? b3.o_if_rdata : b3.o_d_rdata, 64'd0);
    end else begin
      chk("L3 idle rdata", {b3.o_if_rdata, b3.o_d_rdata}, 64'd0);
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dm);
    b1.i_if_req = ir; b1.i_if_addr = ia; b1.i_d_req = dr; b1.i_d_wen = dw;
    b1.i_d_addr = da; b1.i_d_wdata = dwd; b1.i_d_mask = dm;
    b3.i_if_req = ir; b3.i_if_addr = ia; b3.i_d_req = dr; b3.i_d_wen = dw;
    b3.i_d_addr = da; b3.i_d_wdata = dwd; b3.i_d_mask = dm;
  endtask

  task automatic chk_mem(input string tag, input logic [1:0] gnt, input logic req, input logic wen,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                         input logic [1:0] egnt, input logic ereq, input logic ewen,
                         input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] em);
    chk({tag, " gnt {if,d}"}, {62'd0, gnt}, {62'd0, egnt});
    chk({tag, " mem_req"}, {63'd0, req}, {63'd0, ereq});
    chk({tag, " mem_wen"}, {63'd0, wen}, {63'd0, ewen});
    chk({tag, " mem_addr"}, {32'd0, a}, {32'd0, ea});
    chk({tag, " mem_wdata"}, {32'd0, wd}, {32'd0, ewd});
    chk({tag, " mem_mask"}, {60'd0, m}, {60'd0, em});
  endtask

  // One cycle: drive requests, check grant/mux at negedge, record expectations.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dm,
                      input int exp);
    logic [1:0]  egnt;
    logic        ereq, ewen;
    logic [31:0] ea, ewd;
    logic [3:0]  em;
    resp_t       r;
    drive(ir, ia, dr, dw, da, dwd, dm);
    egnt = 2'b00; ereq = 1'b0; ewen = 1'b0; ea = '0; ewd = '0; em = '0;
    if (exp == FI) begin
      egnt = 2'b10; ereq = 1'b1; ea = ia; em = 4'hF;
    end else if (exp == DA) begin
      egnt = 2'b01; ereq = 1'b1; ewen = dw; ea = da; ewd = dwd; em = dm;
    end
    @(negedge clk);
    chk_mem("L1", {b1.o_if_gnt, b1.o_d_gnt}, b1.o_mem_req, b1.o_mem_wen, b1.o_mem_addr,
            b1.o_mem_wdata, b1.o_mem_mask, egnt, ereq, ewen, ea, ewd, em);
    chk_mem("L3", {b3.o_if_gnt, b3.o_d_gnt}, b3.o_mem_req, b3.o_mem_wen, b3.o_mem_addr,
            b3.o_mem_wdata, b3.o_mem_mask, egnt, ereq, ewen, ea, ewd, em);
    if (exp == FI || (exp == DA && !dw)) begin
      r.src  = (exp == DA);
      r.data = (exp == FI) ? refmem[ia[9:2]] : refmem[da[9:2]];
      r.cyc  = cyc + 1;
      q1.push_back(r);
      r.cyc  = cyc + 3;
      q3.push_back(r);
    end
    if (exp == DA && dw)
      for (int b = 0; b < 4; b++)
        if (dm[b]) refmem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, NONE);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " L1 gnt/req/rvalid"}, {59'd0, b1.o_if_gnt, b1.o_d_gnt, b1.o_mem_req,
        b1.o_if_rvalid, b1.o_d_rvalid}, 64'd0);
    chk({tag, " L3 gnt/req/rvalid"}, {59'd0, b3.o_if_gnt, b3.o_d_gnt, b3.o_mem_req,
        b3.o_if_rvalid, b3.o_d_rvalid}, 64'd0);
    chk({tag, " L1 mem_addr"}, {32'd0, b1.o_mem_addr}, 64'd0);
    chk({tag, " L3 mem_addr"}, {32'd0, b3.o_mem_addr}, 64'd0);
    chk({tag, " L1 rdata"}, {b1.o_if_rdata, b1.o_d_rdata}, 64'd0);
    chk({tag, " L3 rdata"}, {b3.o_if_rdata, b3.o_d_rdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] fa, da;
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int k = 0; k < 256; k++) begin
      refmem[k] = 32'hA500_0000 | (k << 4);
    end
    refmem[4] = 32'h0051_3023;
    for (int k = 0; k < 256; k++) begin
      mem1[k] = refmem[k];
      mem3[k] = refmem[k];
    end

    // Reset with requests present: everything must stay quiet.
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, '0, 4'hF);
    #1;
    chk_quiet("reset");
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lone fetch
    step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0, FI);
    idle(3);

    // Both request every cycle: D,D,D,D,I repeating
    fa = 32'h20;
    da = 32'h40;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        step(1'b1, fa, 1'b1, 1'b0, da, '0, 4'hF, FI);
        fa = fa + 4;
      end else begin
        step(1'b1, fa, 1'b1, 1'b0, da, '0, 4'hF, DA);
        da = da + 4;
      end
    end
    idle(3);

    // Store then load of the same word
    step(1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, DA);
    step(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 4'hF, DA);
    idle(3);

    // Back-to-back loads
    step(1'b0, '0, 1'b1, 1'b0, 32'h80, '0, 4'hF, DA);
    step(1'b0, '0, 1'b1, 1'b0, 32'h84, '0, 4'hF, DA);
    step(1'b0, '0, 1'b1, 1'b0, 32'h88, '0, 4'hF, DA);
    idle(3);

    // Streak cleared by a fetch-idle cycle
    for (int k = 0; k < 3; k++) step(1'b1, 32'hC0, 1'b1, 1'b0, 32'h90 + 32'(4 * k), '0, 4'hF, DA);
    step(1'b0, '0, 1'b1, 1'b0, 32'h9C, '0, 4'hF, DA);
    for (int k = 0; k < 4; k++) step(1'b1, 32'hC0, 1'b1, 1'b0, 32'hA0 + 32'(4 * k), '0, 4'hF, DA);
    step(1'b1, 32'hC0, 1'b1, 1'b0, 32'hB0, '0, 4'hF, FI);
    idle(3);

    // Reset mid-flight: two loads outstanding, streak at 2
    step(1'b1, 32'hD0, 1'b1, 1'b0, 32'hE0, '0, 4'hF, DA);
    step(1'b1, 32'hD0, 1'b1, 1'b0, 32'hE4, '0, 4'hF, DA);
    drive(1'b1, 32'hD0, 1'b1, 1'b0, 32'hE8, '0, 4'hF);
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("mid reset");
    q1.delete();
    q3.delete();
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 32'hD0, 1'b1, 1'b0, 32'hE8 + 32'(4 * k), '0, 4'hF, DA);
    step(1'b1, 32'hD0, 1'b1, 1'b0, 32'hF8, '0, 4'hF, FI);
    idle(4);

    chk("L1 responses outstanding", 64'(q1.size()), 64'd0);
    chk("L3 responses outstanding", 64'(q3.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
